// File: rtl/mult_mem_arbiter.sv
// ============================================================================
// Module      : mult_mem_arbiter
// Description : Round-robin arbiter sharing a single-port product buffer SRAM
//               between two requesters. It supports a burst lock, which is
//               broken by a starvation limit. The optional statistics
//               counters are enabled with MULT_MEM_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_mem_arbiter #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
`ifdef MULT_MEM_ARB_STATS_EN
    input  logic              stats_clr,
    output logic [15:0]       gnt_cnt0,
    output logic [15:0]       gnt_cnt1,
    output logic [15:0]       conflict_cnt,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] c_STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [3:0] c_CNT_SAT    = 4'hF;

    logic       r_prio;
    logic       r_owner_valid;
    logic       r_owner;
    logic [3:0] r_starve_cnt;
    logic       r_rd_pend0;
    logic       r_rd_pend1;

    logic       w_both;
    logic       w_pick1;
    logic       w_any_gnt;
    logic       w_gnt_lock;
    logic       w_owner_hold;

    always_comb begin
        w_both = req0 & req1;
        // The lock only wins a conflict until the starvation budget runs out.
        if (w_both) begin
            if (r_owner_valid && (r_starve_cnt < c_STARVE_LIM)) begin
                w_pick1 = r_owner;
            end else begin
                w_pick1 = r_prio;
            end
        end else begin
            w_pick1 = req1;
        end
        gnt0         = ~rst & req0 & ~w_pick1;
        gnt1         = ~rst & req1 & w_pick1;
        w_any_gnt    = gnt0 | gnt1;
        w_gnt_lock   = gnt0 ? lock0 : lock1;
        w_owner_hold = r_owner_valid & w_both & (r_owner ? gnt1 : gnt0);
    end

    always_comb begin
        mem_en    = w_any_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (gnt1) begin
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
        rvalid0 = r_rd_pend0 & ~rst;
        rvalid1 = r_rd_pend1 & ~rst;
        rdata0  = rvalid0 ? mem_rdata : '0;
        rdata1  = rvalid1 ? mem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio        <= 1'b0;
            r_owner_valid <= 1'b0;
            r_owner       <= 1'b0;
            r_starve_cnt  <= 4'd0;
            r_rd_pend0    <= 1'b0;
            r_rd_pend1    <= 1'b0;
        end else begin
            r_rd_pend0 <= gnt0 & ~we0;
            r_rd_pend1 <= gnt1 & ~we1;
            // A cycle without any grant means the lock holder dropped req.
            if (w_any_gnt) begin
                r_prio        <= gnt0;
                r_owner_valid <= w_gnt_lock;
                r_owner       <= gnt1;
            end else begin
                r_owner_valid <= 1'b0;
            end
            if (w_owner_hold) begin
                if (r_starve_cnt != c_CNT_SAT) begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end
            end else begin
                r_starve_cnt <= 4'd0;
            end
        end
    end

`ifdef MULT_MEM_ARB_STATS_EN
    localparam logic [15:0] c_STAT_SAT = 16'hFFFF;

    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            gnt_cnt0     <= 16'd0;
            gnt_cnt1     <= 16'd0;
            conflict_cnt <= 16'd0;
        end else begin
            if (gnt0 && (gnt_cnt0 != c_STAT_SAT)) begin
                gnt_cnt0 <= gnt_cnt0 + 16'd1;
            end
            if (gnt1 && (gnt_cnt1 != c_STAT_SAT)) begin
                gnt_cnt1 <= gnt_cnt1 + 16'd1;
            end
            if (w_both && (conflict_cnt != c_STAT_SAT)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mult_mem_arbiter.sv
// ============================================================================
// Module      : tb_mult_mem_arbiter
// Description : Self-checking bench for mult_mem_arbiter, with an SRAM model
//               and a read-data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_mem_arbiter;

    typedef struct {
        logic        r0, w0, l0;
        logic [5:0]  a0;
        logic [15:0] d0;
        logic        r1, w1, l1;
        logic [5:0]  a1;
        logic [15:0] d1;
        logic        eg0, eg1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, lock0, req1, we1, lock1;
    logic [5:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic        mem_en, mem_we;
    logic [5:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
`ifdef MULT_MEM_ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
`endif

    logic [15:0] sram    [64];
    logic [15:0] ref_mem [64];
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic        exp_pend0, exp_pend1;
    int          checks = 0;
    int          errors = 0;
    vec_t        tab[11];

    always #5 clk = ~clk;

    mult_mem_arbiter #(.ADDR_W(6), .DATA_W(16), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
`ifdef MULT_MEM_ARB_STATS_EN
        .stats_clr(stats_clr), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1),
        .conflict_cnt(conflict_cnt),
`endif
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [15:0] pat(input int i);
        return 16'(i * 257) ^ 16'h5A5A;
    endfunction

    // Single-port SRAM with 1-cycle read latency; contents reload on reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) sram[i] <= pat(i);
            mem_rdata <= 16'd0;
        end else if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= sram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_return(input string name);
        logic [15:0] e;
        chk({name, "_rvalid0"}, 40'(rvalid0), 40'(exp_pend0));
        chk({name, "_rvalid1"}, 40'(rvalid1), 40'(exp_pend1));
        if (exp_pend0) begin
            e = (q0.size() > 0) ? q0.pop_front() : 16'hxxxx;
            chk({name, "_rdata0"}, 40'(rdata0), 40'(e));
        end
        if (exp_pend1) begin
            e = (q1.size() > 0) ? q1.pop_front() : 16'hxxxx;
            chk({name, "_rdata1"}, 40'(rdata1), 40'(e));
        end
    endtask

    // Called at posedge+1; drives one cycle and checks it at the falling edge.
    task automatic step(input vec_t v, input string name);
        logic [23:0] exp_mem;
        req0 = v.r0; we0 = v.w0; lock0 = v.l0; addr0 = v.a0; wdata0 = v.d0;
        req1 = v.r1; we1 = v.w1; lock1 = v.l1; addr1 = v.a1; wdata1 = v.d1;
        @(negedge clk);
        check_return(name);
        chk({name, "_gnt"}, 40'({gnt0, gnt1}), 40'({v.eg0, v.eg1}));
        if (v.eg0)      exp_mem = {1'b1, v.w0, v.a0, v.d0};
        else if (v.eg1) exp_mem = {1'b1, v.w1, v.a1, v.d1};
        else            exp_mem = 24'd0;
        chk({name, "_mem"}, 40'({mem_en, mem_we, mem_addr, mem_wdata}), 40'(exp_mem));
        exp_pend0 = v.eg0 & ~v.w0;
        exp_pend1 = v.eg1 & ~v.w1;
        if (v.eg0 &&  v.w0) ref_mem[v.a0] = v.d0;
        if (v.eg0 && !v.w0) q0.push_back(ref_mem[v.a0]);
        if (v.eg1 &&  v.w1) ref_mem[v.a1] = v.d1;
        if (v.eg1 && !v.w1) q1.push_back(ref_mem[v.a1]);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            @(negedge clk);
            chk("reset_outputs",
                40'({gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata}),
                40'd0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        exp_pend0 = 1'b0;
        exp_pend1 = 1'b0;
        q0.delete();
        q1.delete();
        for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
    endtask

    function automatic vec_t mk(input logic r0, w0, l0, input logic [5:0] a0, input logic [15:0] d0,
                                input logic r1, w1, l1, input logic [5:0] a1, input logic [15:0] d1,
                                input logic eg0, eg1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
        v.eg0 = eg0; v.eg1 = eg1;
        return v;
    endfunction

    initial begin
        vec_t idle;
        vec_t v;
        int   k;
        logic r0;

        idle = mk(0, 0, 0, 6'd0, 16'd0, 0, 0, 0, 6'd0, 16'd0, 0, 0);
        // Round-robin: both read continuously, grants alternate from 0.
        for (int i = 0; i < 8; i++)
            tab[i] = mk(1, 0, 0, 6'd10, 16'd0, 1, 0, 0, 6'd20, 16'd0, (i % 2) == 0, (i % 2) == 1);
        // Read-after-write through different requesters.
        tab[8]  = mk(1, 1, 0, 6'd5, 16'hBEEF, 0, 0, 0, 6'd0, 16'd0, 1, 0);
        tab[9]  = mk(0, 0, 0, 6'd0, 16'd0, 1, 0, 0, 6'd5, 16'd0, 0, 1);
        tab[10] = idle;

        req0 = 0; we0 = 0; lock0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; lock1 = 0; addr1 = 0; wdata1 = 0;
        exp_pend0 = 0; exp_pend1 = 0;
        rst = 1'b1;
        @(posedge clk); #1;

        do_reset(2);
        repeat (3) step(idle, "idle");

        for (int i = 0; i < 64; i++)
            step(mk(1, 1, 0, 6'(i), 16'(i * 3), 0, 0, 0, 6'd0, 16'd0, 1, 0), "single_wr");
        for (int i = 0; i < 8; i++)
            step(mk(0, 0, 0, 6'd0, 16'd0, 1, 0, 0, 6'(i), 16'd0, 0, 1), "readback");
        step(idle, "readback_drain");

        do_reset(1);
        for (int i = 0; i < 11; i++) step(tab[i], (i < 8) ? "round_robin" : "raw");

        // Burst lock by requester 1; requester 0 contends in two windows.
        do_reset(1);
        k = 0;
        for (int c = 0; k < 64; c++) begin
            r0 = ((c >= 10) && (c <= 14)) || ((c >= 16) && (c <= 20));
            v = mk(r0, 0, 0, 6'd7, 16'd0, 1, 0, 1, 6'(k), 16'd0,
                   (c == 14) || (c == 20), !((c == 14) || (c == 20)));
            step(v, "burst");
            if (v.eg1) k++;
        end
        step(idle, "burst_drain");

        // Reset one cycle after a locked read grant.
        step(mk(0, 0, 0, 6'd0, 16'd0, 1, 0, 1, 6'd3, 16'd0, 0, 1), "pre_reset");
        do_reset(1);
        step(mk(1, 0, 0, 6'd9, 16'd0, 1, 0, 1, 6'd3, 16'd0, 1, 0), "post_reset");
        step(idle, "post_reset_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
